// File: rtl/regfile_arbiter.sv
// Round-robin arbiter sharing a single-port register file between requesters A and B.
// Each granted access runs as a fixed IDLE -> ACCESS -> DONE transaction.
module regfile_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_data,
    output logic              rf_write,
    input  logic [DATA_W-1:0] rf_out,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_prio;     // 0 = A has priority, 1 = B
    logic              r_winner;   // 0 = A granted, 1 = B
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] r_a_rdata;
    logic [DATA_W-1:0] r_b_rdata;
    logic              w_any_req;
    logic              w_pick_b;

    assign w_any_req = a_req | b_req;
    assign w_pick_b  = (a_req && b_req) ? r_prio : b_req;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    // NOTE: default first in every always_comb, so no path leaves a signal unassigned (no latch).
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_any_req) w_next = ACCESS;
            ACCESS:  w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // rf_write is decoded from state so an async reset removes it in the same cycle.
    always_comb begin
        rf_write = 1'b0;
        a_ack    = 1'b0;
        b_ack    = 1'b0;
        busy     = (r_state != IDLE);
        case (r_state)
            ACCESS:  rf_write = r_we;
            DONE: begin
                a_ack = ~r_winner;
                b_ack = r_winner;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prio    <= 1'b0;
            r_winner  <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_data    <= '0;
            r_a_rdata <= '0;
            r_b_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_any_req) begin
                    r_winner <= w_pick_b;
                    r_we     <= w_pick_b ? b_we   : a_we;
                    r_addr   <= w_pick_b ? b_addr : a_addr;
                    // Reads leave the data pins at their last written value.
                    if (w_pick_b ? b_we : a_we)
                        r_data <= w_pick_b ? b_wdata : a_wdata;
                end
                ACCESS: if (!r_we) begin
                    if (r_winner) r_b_rdata <= rf_out;
                    else          r_a_rdata <= rf_out;
                end
                DONE:    r_prio <= ~r_prio;
                default: ;
            endcase
        end
    end

    assign rf_addr = r_addr;
    assign rf_data = r_data;
    assign a_rdata = r_a_rdata;
    assign b_rdata = r_b_rdata;

endmodule
